serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving operand width in bits (legal range 1..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1, meaning an operand pair is offered.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block can accept an operand pair.
REQ-006 The block SHALL have port a, input, WIDTH, the first operand.
REQ-007 The block SHALL have port b, input, WIDTH, the second operand.
REQ-008 The block SHALL have port out_valid, output, 1, meaning the result is available.
REQ-009 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-010 The block SHALL have port sum, output, WIDTH, the result bits (a+b) mod 2^WIDTH.
REQ-011 The block SHALL have port carry, output, 1, the carry-out of the MSB.
REQ-012 The block SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-013 The block SHALL use an FSM with exactly three states: IDLE, RUN, DONE.
REQ-014 The block SHALL drive in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-015 In IDLE, when in_valid=1 on a clock edge, the block SHALL latch a and b, clear the carry register, clear the bit counter to 0, and go to RUN.
REQ-016 In RUN, each cycle the block SHALL add exactly one bit, LSB first.
REQ-017 Each per-bit step SHALL be one 1-bit full add built from two half-adder stages: s = a_i ^ b_i ^ c, c_next = (a_i & b_i) | ((a_i ^ b_i) & c).
REQ-018 The block SHALL shift the sum bit into the result register at bit position [counter].
REQ-019 The bit counter SHALL increment by 1 per RUN cycle; when the counter equals WIDTH-1 the block SHALL go to DONE on that edge.
REQ-020 RUN SHALL therefore last exactly WIDTH cycles, so out_valid rises WIDTH clock edges after the accepting edge.
REQ-021 In DONE, sum and carry SHALL stay stable until the edge where out_ready=1, then the block SHALL go to IDLE.
REQ-022 The result SHALL stay visible on sum/carry in IDLE until the next operand pair is accepted.
REQ-023 in_valid SHALL be ignored in RUN and DONE; a and b SHALL NOT be re-sampled mid-operation.
REQ-024 If out_ready=1 and in_valid=1 in the same DONE cycle, the block SHALL complete the output handshake only; the new operand is accepted no earlier than the following IDLE cycle.
REQ-025 With WIDTH=1, RUN SHALL last one cycle and carry SHALL equal a[0]&b[0].
REQ-026 For overflow, sum SHALL wrap modulo 2^WIDTH and carry SHALL be 1 exactly when a+b >= 2^WIDTH.
REQ-027 The block SHALL produce no combinational path from any input to any output except none; all outputs SHALL be registered or decoded from state.

Reset
REQ-028 On rst=1 the block SHALL immediately, without waiting for clk, enter IDLE with sum=0, carry=0, out_valid=0, busy=0, counter=0, operand registers=0, and in_ready=1 once rst deasserts.
REQ-029 Asserting rst in RUN or DONE SHALL abort the operation and discard its partial result, with no out_valid pulse afterwards.

Verification
REQ-030 The bench SHALL check: WIDTH=8, a=0x00, b=0x00 -> after 8 cycles out_valid=1, sum=0x00, carry=0.
REQ-031 The bench SHALL check: a=0xFF, b=0x01 -> sum=0x00, carry=1; a=0xA5, b=0x5A -> sum=0xFF, carry=0.
REQ-032 The bench SHALL check backpressure: out_ready held 0 for 3 cycles in DONE -> out_valid, sum, carry unchanged throughout; out_ready=1 -> IDLE on the next edge.
REQ-033 The bench SHALL check: in_valid pulsed with a=0x11, b=0x22 during RUN of 0x03+0x04 -> result 0x07, carry=0, and the second pair is not accepted.
REQ-034 The bench SHALL check: rst asserted at RUN cycle 4 -> outputs zero asynchronously, in_ready=1 after release, no stale out_valid.
REQ-035 The bench SHALL run an exhaustive WIDTH=4 sweep of all 256 a/b pairs -> {carry,sum} equals a+b for every pair.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder behind a valid/ready handshake: accepts an operand pair,
// adds one bit per cycle LSB first, then holds {carry,sum} until taken.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [CW-1:0]    cnt;

    logic a_bit;
    logic b_bit;
    logic half_sum;
    logic half_carry;
    logic bit_sum;
    logic bit_carry;

    // One full add per cycle, built from two half-adder stages; carry is the running carry.
    always_comb begin
        a_bit      = op_a[cnt];
        b_bit      = op_b[cnt];
        half_sum   = a_bit ^ b_bit;
        half_carry = a_bit & b_bit;
        bit_sum    = half_sum ^ carry;
        bit_carry  = half_carry | (half_sum & carry);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            cnt       <= '0;
            sum       <= '0;
            carry     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a     <= a;
                        op_b     <= b;
                        cnt      <= '0;
                        sum      <= '0;
                        carry    <= 1'b0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    sum[cnt] <= bit_sum;
                    carry    <= bit_carry;
                    cnt      <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // A new in_valid here is deliberately ignored; it is taken from IDLE next cycle.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed and random cases on an
// 8-bit instance, reset abort, and an exhaustive sweep on a 4-bit instance.
module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       carry;
    logic       busy;

    logic       in_valid4;
    logic       in_ready4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       out_valid4;
    logic       out_ready4;
    logic [3:0] sum4;
    logic       carry4;
    logic       busy4;

    int compared;
    int mismatched;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry(carry), .busy(busy)
    );

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .carry(carry4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; all driving and sampling happens there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full 8-bit transaction checked against plain integer addition.
    task automatic applyStimulus(input logic [7:0] opa, input logic [7:0] opb,
                                 input int stall, input bit interfere, input bit collide);
        logic [8:0] expv;
        expv = {1'b0, opa} + {1'b0, opb};
        checkOutput("pre_in_ready", in_ready, 1);
        in_valid = 1'b1;
        a = opa;
        b = opb;
        tick();
        in_valid = 1'b0;
        checkOutput("accept_busy", busy, 1);
        checkOutput("accept_in_ready", in_ready, 0);
        for (int k = 1; k <= 8; k++) begin
            if (interfere && k == 3) begin
                in_valid = 1'b1;
                a = 8'h11;
                b = 8'h22;
            end
            if (interfere && k == 4) in_valid = 1'b0;
            tick();
            if (k == 7) checkOutput("early_valid", out_valid, 0);
        end
        checkOutput("out_valid", out_valid, 1);
        checkOutput("sum", sum, expv[7:0]);
        checkOutput("carry", carry, expv[8]);
        for (int s = 0; s < stall; s++) begin
            tick();
            checkOutput("hold_valid", out_valid, 1);
            checkOutput("hold_sum", sum, expv[7:0]);
            checkOutput("hold_carry", carry, expv[8]);
        end
        out_ready = 1'b1;
        if (collide) begin
            in_valid = 1'b1;
            a = 8'h55;
            b = 8'h66;
        end
        tick();
        out_ready = 1'b0;
        in_valid = 1'b0;
        checkOutput("release_valid", out_valid, 0);
        checkOutput("release_in_ready", in_ready, 1);
        checkOutput("release_busy", busy, 0);
        checkOutput("idle_sum", sum, expv[7:0]);
        checkOutput("idle_carry", carry, expv[8]);
        tick();
        checkOutput("idle_not_taken", busy, 0);
    endtask

    task automatic run4(input logic [3:0] opa, input logic [3:0] opb);
        logic [4:0] expv;
        bit         seen;
        expv = {1'b0, opa} + {1'b0, opb};
        seen = 1'b0;
        in_valid4 = 1'b1;
        a4 = opa;
        b4 = opb;
        tick();
        in_valid4 = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            if (out_valid4) seen = 1'b1;
        end
        if (!seen) checkOutput("w4_timeout", 0, 1);
        else checkOutput($sformatf("w4_%0h+%0h", opa, opb), {carry4, sum4}, expv);
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
    endtask

    initial begin
        bit stale;
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        a          = '0;
        b          = '0;
        in_valid4  = 1'b0;
        out_ready4 = 1'b0;
        a4         = '0;
        b4         = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_sum", sum, 0);
        checkOutput("rst_carry", carry, 0);

        $display("[TB] directed cases");
        applyStimulus(8'h00, 8'h00, 0, 1'b0, 1'b0);
        applyStimulus(8'hFF, 8'h01, 0, 1'b0, 1'b0);
        applyStimulus(8'hA5, 8'h5A, 0, 1'b0, 1'b0);
        applyStimulus(8'h80, 8'h80, 3, 1'b0, 1'b0);
        applyStimulus(8'h03, 8'h04, 0, 1'b1, 1'b0);
        applyStimulus(8'h7F, 8'h7F, 1, 1'b0, 1'b1);

        $display("[TB] random cases");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)),
                          1'($urandom), 1'($urandom));
        end

        $display("[TB] reset abort");
        in_valid = 1'b1;
        a = 8'hFF;
        b = 8'hFF;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        checkOutput("abort_busy_before", busy, 1);
        #2;
        rst = 1'b1;
        #2;
        checkOutput("abort_sum", sum, 0);
        checkOutput("abort_carry", carry, 0);
        checkOutput("abort_out_valid", out_valid, 0);
        checkOutput("abort_busy", busy, 0);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("abort_in_ready", in_ready, 1);
        stale = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (out_valid) stale = 1'b1;
        end
        checkOutput("abort_no_stale_valid", stale, 0);
        checkOutput("abort_idle_ready", in_ready, 1);
        applyStimulus(8'h12, 8'h34, 0, 1'b0, 1'b0);

        $display("[TB] exhaustive 4-bit sweep");
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                run4(4'(x), 4'(y));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
